// File: rtl/slim_patrol_pkg.sv
// Shared slime constants: walk/pause state encoding plus sprite and screen sizes.
// The blue-vs-slime collision detector uses the same constants.
package slim_pkg;

    typedef enum logic [2:0] {
        WALK_R  = 3'd0,
        WALK_L  = 3'd1,
        PAUSE_R = 3'd2,
        PAUSE_L = 3'd3
    } slim_state_e;

    localparam int unsigned SLIM_W   = 62;
    localparam int unsigned SLIM_H   = 36;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    function automatic logic is_walk(input slim_state_e s);
        return (s == WALK_R) || (s == WALK_L);
    endfunction

endpackage

// File: rtl/slim_patrol_tick_gen.sv
// Motion prescaler: raises a one-cycle tick every STEP_DIV clocks.
// While hold is high the count is pinned at zero and no tick is produced.
module tick_gen
    import slim_pkg::*;
#(
    parameter logic [31:0] STEP_DIV = 32'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    logic [31:0] count_q, count_d;

    always_comb begin
        tick    = !hold && (count_q == STEP_DIV - 32'd1);
        count_d = (hold || tick) ? '0 : count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/slim_patrol.sv
// Slime patrol: walks between X_MIN and X_MAX on prescaled ticks and freezes on `frozen`.
// Define SLIM_TURN_PAUSE_EN to pause PAUSE_TICKS ticks at each bound before reversing.
module slim_patrol
    import slim_pkg::*;
#(
    parameter logic [9:0]  X_MIN       = 10'd0,
    parameter logic [9:0]  X_MAX       = 10'd578,
    parameter logic [9:0]  X_START     = 10'd200,
    parameter logic [8:0]  Y_FLOOR     = 9'd400,
    parameter logic [31:0] STEP_DIV    = 32'd1_000_000,
    parameter logic [9:0]  STEP_PX     = 10'd2,
    parameter logic [3:0]  ANIM_DIV    = 4'd8,
    parameter logic [3:0]  PAUSE_TICKS = 4'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frozen,
    output logic [9:0] x_slim,
    output logic [8:0] y_slim,
    output logic       dir,
    output logic [1:0] anim,
    output logic       moving
);

    if (!(X_MIN <= X_START && X_START <= X_MAX && STEP_DIV >= 32'd2 &&
          ANIM_DIV != 4'd0 && PAUSE_TICKS != 4'd0)) begin : g_cfg_err
        $error("slim_patrol: invalid parameter set");
    end

    logic tick;

    tick_gen #(.STEP_DIV(STEP_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .hold (frozen),
        .tick (tick)
    );

    slim_state_e state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        dir_q, dir_d;
    logic [1:0]  anim_q, anim_d, anim_nx;
    logic [3:0]  anim_cnt_q, anim_cnt_d, anim_cnt_nx;
    logic        moving_q, moving_d;
    logic [10:0] sum_r, lim_l;
`ifdef SLIM_TURN_PAUSE_EN
    logic [3:0]  pause_cnt_q, pause_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        anim_d     = anim_q;
        anim_cnt_d = anim_cnt_q;
`ifdef SLIM_TURN_PAUSE_EN
        pause_cnt_d = pause_cnt_q;
`endif
        // 11-bit bound arithmetic so neither bound test can wrap
        sum_r = {1'b0, x_q} + {1'b0, STEP_PX};
        lim_l = {1'b0, X_MIN} + {1'b0, STEP_PX};

        if (anim_cnt_q == ANIM_DIV - 4'd1) begin
            anim_cnt_nx = '0;
            anim_nx     = anim_q + 2'd1;
        end else begin
            anim_cnt_nx = anim_cnt_q + 4'd1;
            anim_nx     = anim_q;
        end

        if (!frozen && tick) begin
            unique case (state_q)
                WALK_R: begin
                    if (sum_r >= {1'b0, X_MAX}) begin
                        x_d        = X_MAX;
                        dir_d      = 1'b0;
                        anim_d     = '0;
                        anim_cnt_d = '0;
`ifdef SLIM_TURN_PAUSE_EN
                        state_d    = PAUSE_R;
`else
                        state_d    = WALK_L;
`endif
                    end else begin
                        x_d        = sum_r[9:0];
                        anim_d     = anim_nx;
                        anim_cnt_d = anim_cnt_nx;
                    end
                end
                WALK_L: begin
                    if ({1'b0, x_q} <= lim_l) begin
                        x_d        = X_MIN;
                        dir_d      = 1'b1;
                        anim_d     = '0;
                        anim_cnt_d = '0;
`ifdef SLIM_TURN_PAUSE_EN
                        state_d    = PAUSE_L;
`else
                        state_d    = WALK_R;
`endif
                    end else begin
                        x_d        = x_q - STEP_PX;
                        anim_d     = anim_nx;
                        anim_cnt_d = anim_cnt_nx;
                    end
                end
`ifdef SLIM_TURN_PAUSE_EN
                PAUSE_R, PAUSE_L: begin
                    if (pause_cnt_q == PAUSE_TICKS - 4'd1) begin
                        pause_cnt_d = '0;
                        state_d     = (state_q == PAUSE_R) ? WALK_L : WALK_R;
                    end else begin
                        pause_cnt_d = pause_cnt_q + 4'd1;
                    end
                end
`endif
                default: ;
            endcase
        end

        moving_d = is_walk(state_d) && !frozen;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WALK_R;
            x_q         <= X_START;
            y_q         <= Y_FLOOR;
            dir_q       <= 1'b1;
            anim_q      <= '0;
            anim_cnt_q  <= '0;
            moving_q    <= 1'b1;
`ifdef SLIM_TURN_PAUSE_EN
            pause_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
            anim_q      <= anim_d;
            anim_cnt_q  <= anim_cnt_d;
            moving_q    <= moving_d;
`ifdef SLIM_TURN_PAUSE_EN
            pause_cnt_q <= pause_cnt_d;
`endif
        end
    end

    assign x_slim = x_q;
    assign y_slim = y_q;
    assign dir    = dir_q;
    assign anim   = anim_q;
    assign moving = moving_q;

endmodule

// File: tb/tb_slim_patrol.sv
// Self-checking bench for slim_patrol: three instances with different bounds/starts
// checked by directed scenarios and a randomized freeze run against a behavioural model.
module tb_slim_patrol;

    localparam int SD = 4;
    localparam int STEP = 2;
    localparam int AD = 2;
`ifdef SLIM_TURN_PAUSE_EN
    localparam int PT = 3;
`else
    localparam int PT = 0;
`endif
    localparam int XMAXS [3]   = '{20, 20, 21};
    localparam int XSTARTS [3] = '{10, 19, 19};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frozen = 1'b0;

    logic [9:0] x_o [3];
    logic [8:0] y_o [3];
    logic       dir_o [3];
    logic [1:0] anim_o [3];
    logic       mov_o [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    slim_patrol #(.X_MIN(10'd0), .X_MAX(10'd20), .X_START(10'd10), .Y_FLOOR(9'd400),
                  .STEP_DIV(32'd4), .STEP_PX(10'd2), .ANIM_DIV(4'd2), .PAUSE_TICKS(4'd3)) u_dut0 (
        .clk(clk), .rst(rst), .frozen(frozen), .x_slim(x_o[0]), .y_slim(y_o[0]),
        .dir(dir_o[0]), .anim(anim_o[0]), .moving(mov_o[0]));

    slim_patrol #(.X_MIN(10'd0), .X_MAX(10'd20), .X_START(10'd19), .Y_FLOOR(9'd400),
                  .STEP_DIV(32'd4), .STEP_PX(10'd2), .ANIM_DIV(4'd2), .PAUSE_TICKS(4'd3)) u_dut1 (
        .clk(clk), .rst(rst), .frozen(frozen), .x_slim(x_o[1]), .y_slim(y_o[1]),
        .dir(dir_o[1]), .anim(anim_o[1]), .moving(mov_o[1]));

    slim_patrol #(.X_MIN(10'd0), .X_MAX(10'd21), .X_START(10'd19), .Y_FLOOR(9'd400),
                  .STEP_DIV(32'd4), .STEP_PX(10'd2), .ANIM_DIV(4'd2), .PAUSE_TICKS(4'd3)) u_dut2 (
        .clk(clk), .rst(rst), .frozen(frozen), .x_slim(x_o[2]), .y_slim(y_o[2]),
        .dir(dir_o[2]), .anim(anim_o[2]), .moving(mov_o[2]));

    // Behavioural model: position, heading, ticks left in a pause, animation progress
    int mx [3];
    bit mright [3];
    int manim [3];
    int macnt [3];
    int mpause [3];
    bit mmov [3];
    int mpre;
    bit mvalid;

    task automatic model_step();
        bit tk;
        if (rst) begin
            mpre = 0;
            mvalid = 0;
            for (int i = 0; i < 3; i++) begin
                mx[i] = XSTARTS[i]; mright[i] = 1; manim[i] = 0; macnt[i] = 0;
                mpause[i] = 0; mmov[i] = 1;
            end
        end else begin
            mvalid = 1;
            if (frozen) begin
                mpre = 0;
                for (int i = 0; i < 3; i++) mmov[i] = 0;
            end else begin
                tk = (mpre == SD - 1);
                mpre = tk ? 0 : mpre + 1;
                for (int i = 0; i < 3; i++) begin
                    if (tk) begin
                        if (mpause[i] > 0) begin
                            mpause[i]--;
                        end else if ((mright[i] && mx[i] + STEP >= XMAXS[i]) ||
                                     (!mright[i] && mx[i] <= STEP)) begin
                            mx[i] = mright[i] ? XMAXS[i] : 0;
                            mright[i] = !mright[i];
                            manim[i] = 0; macnt[i] = 0; mpause[i] = PT;
                        end else begin
                            mx[i] = mright[i] ? mx[i] + STEP : mx[i] - STEP;
                            macnt[i]++;
                            if (macnt[i] == AD) begin
                                macnt[i] = 0;
                                manim[i] = (manim[i] + 1) % 4;
                            end
                        end
                    end
                    mmov[i] = (mpause[i] == 0);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    task automatic do_reset();
        frozen = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        frozen = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (x_o[i] !== 10'(XSTARTS[i])) begin
                errors++; $display("FAIL reset_x[%0d]: got %0d want %0d", i, x_o[i], XSTARTS[i]);
            end
            checks++;
            if (y_o[i] !== 9'd400) begin
                errors++; $display("FAIL reset_y[%0d]: got %0d want 400", i, y_o[i]);
            end
            checks++;
            if (dir_o[i] !== 1'b1) begin
                errors++; $display("FAIL reset_dir[%0d]: got %b want 1", i, dir_o[i]);
            end
            checks++;
            if (anim_o[i] !== 2'd0) begin
                errors++; $display("FAIL reset_anim[%0d]: got %0d want 0", i, anim_o[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_walk_right();
        int exp_anim;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            repeat (4) @(negedge clk);
            exp_anim = (k == 5) ? 0 : k / 2;
            checks++;
            if (x_o[0] !== 10'(10 + 2 * k)) begin
                errors++; $display("FAIL walk_x k=%0d: got %0d want %0d", k, x_o[0], 10 + 2 * k);
            end
            checks++;
            if (dir_o[0] !== (k < 5)) begin
                errors++; $display("FAIL walk_dir k=%0d: got %b want %b", k, dir_o[0], k < 5);
            end
            checks++;
            if (anim_o[0] !== 2'(exp_anim)) begin
                errors++; $display("FAIL walk_anim k=%0d: got %0d want %0d", k, anim_o[0], exp_anim);
            end
            if (k == 1) begin
                checks++;
                if (x_o[1] !== 10'd20 || dir_o[1] !== 1'b0) begin
                    errors++; $display("FAIL clamp_right: got x=%0d dir=%b want x=20 dir=0", x_o[1], dir_o[1]);
                end
            end
        end
        for (int p = 1; p <= PT; p++) begin
            repeat (4) @(negedge clk);
            checks++;
            if (x_o[0] !== 10'd20 || mov_o[0] !== 1'b0) begin
                errors++; $display("FAIL pause_hold p=%0d: got x=%0d moving=%b want x=20 moving=0", p, x_o[0], mov_o[0]);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (x_o[0] !== 10'd18 || dir_o[0] !== 1'b0) begin
            errors++; $display("FAIL first_left: got x=%0d dir=%b want x=18 dir=0", x_o[0], dir_o[0]);
        end
    endtask

    task automatic test_left_bound();
        int n;
        do_reset();
        n = 0;
        while (x_o[2] !== 10'd1 && n < 300) begin
            @(negedge clk); n++;
        end
        checks++;
        if (x_o[2] !== 10'd1) begin
            errors++; $display("FAIL reach_x1: got %0d want 1 within 300 cycles", x_o[2]);
        end else begin
            n = 0;
            while (x_o[2] === 10'd1 && n < 40) begin
                @(negedge clk); n++;
            end
            checks++;
            if (x_o[2] !== 10'd0 || dir_o[2] !== 1'b1 || anim_o[2] !== 2'd0) begin
                errors++; $display("FAIL left_clamp: got x=%0d dir=%b anim=%0d want x=0 dir=1 anim=0",
                                   x_o[2], dir_o[2], anim_o[2]);
            end
        end
    endtask

    task automatic test_frozen();
        int n;
        do_reset();
        repeat (8) @(negedge clk);
        checks++;
        if (x_o[0] !== 10'd14) begin
            errors++; $display("FAIL pre_freeze_x: got %0d want 14", x_o[0]);
        end
        repeat (2) @(negedge clk);
        frozen = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (x_o[0] !== 10'd14 || dir_o[0] !== 1'b1 || anim_o[0] !== 2'd1 || mov_o[0] !== 1'b0) begin
                errors++; $display("FAIL freeze_hold c=%0d: got x=%0d dir=%b anim=%0d moving=%b want 14 1 1 0",
                                   c, x_o[0], dir_o[0], anim_o[0], mov_o[0]);
            end
        end
        frozen = 1'b0;
        n = 0;
        while (x_o[0] === 10'd14 && n < 10) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n !== 4 || x_o[0] !== 10'd16) begin
            errors++; $display("FAIL release_latency: got %0d cycles x=%0d want 4 cycles x=16", n, x_o[0]);
        end
    endtask

    task automatic test_frozen_tick();
        do_reset();
        repeat (3) @(negedge clk);
        frozen = 1'b1;
        @(negedge clk);
        checks++;
        if (x_o[0] !== 10'd10 || mov_o[0] !== 1'b0) begin
            errors++; $display("FAIL frozen_tick: got x=%0d moving=%b want x=10 moving=0", x_o[0], mov_o[0]);
        end
        frozen = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (x_o[0] !== 10'd10) begin
            errors++; $display("FAIL frozen_tick_early: got x=%0d want 10", x_o[0]);
        end
        @(negedge clk);
        checks++;
        if (x_o[0] !== 10'd12 || mov_o[0] !== 1'b1) begin
            errors++; $display("FAIL frozen_tick_resume: got x=%0d moving=%b want x=12 moving=1", x_o[0], mov_o[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (26) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (x_o[i] !== 10'(XSTARTS[i]) || y_o[i] !== 9'd400 || dir_o[i] !== 1'b1 || anim_o[i] !== 2'd0) begin
                errors++; $display("FAIL async_reset[%0d]: got x=%0d y=%0d dir=%b anim=%0d want %0d 400 1 0",
                                   i, x_o[i], y_o[i], dir_o[i], anim_o[i], XSTARTS[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random_patrol();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (x_o[i] !== 10'(mx[i])) begin
                    errors++; $display("FAIL rnd_x[%0d] c=%0d: got %0d want %0d", i, c, x_o[i], mx[i]);
                end
                checks++;
                if (y_o[i] !== 9'd400) begin
                    errors++; $display("FAIL rnd_y[%0d] c=%0d: got %0d want 400", i, c, y_o[i]);
                end
                checks++;
                if (dir_o[i] !== mright[i]) begin
                    errors++; $display("FAIL rnd_dir[%0d] c=%0d: got %b want %b", i, c, dir_o[i], mright[i]);
                end
                checks++;
                if (anim_o[i] !== 2'(manim[i])) begin
                    errors++; $display("FAIL rnd_anim[%0d] c=%0d: got %0d want %0d", i, c, anim_o[i], manim[i]);
                end
                if (mvalid) begin
                    checks++;
                    if (mov_o[i] !== mmov[i]) begin
                        errors++; $display("FAIL rnd_moving[%0d] c=%0d: got %b want %b", i, c, mov_o[i], mmov[i]);
                    end
                end
            end
            frozen = ($urandom_range(0, 4) == 0);
        end
        frozen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_walk_right();
        test_left_bound();
        test_frozen();
        test_frozen_tick();
        test_async_reset();
        test_random_patrol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
